// File: rtl/ex_div_unit_if.sv
// Pipeline-side bundle for the EX-stage divide unit: ID/EX operands in,
// stall/busy status and the one-cycle write-back result out.
interface ex_div_unit_if;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        hold_o;
    logic        busy_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;

    modport master (
        output inst_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  hold_o, busy_o, wb_valid_o, wb_data_o, wb_rd_o
    );

    modport slave (
        input  inst_i, op1_i, op2_i, rd_addr_i, flush_i,
        output hold_o, busy_o, wb_valid_o, wb_data_o, wb_rd_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit (restoring, ITER_PER_CLK bits per clock).
// Optional macro EX_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor| or |divisor| == 1.
module ex_div_unit #(
    parameter int unsigned ITER_PER_CLK = 1
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  bus
);

    localparam int unsigned N_CYC    = 32 / ITER_PER_CLK;
    localparam logic [5:0]  CNT_LAST = 6'(N_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_q, neg_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        hold_c;

    // ------------------------------------------------------------------
    // Decode and operand preparation
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_div_op;
    logic        op_signed;
    logic        op_rem;
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic        res_neg;
    logic        div_zero;
    logic        sgn_ovf;
    logic [31:0] special_res;
    logic        early;
    logic [31:0] early_res;
    logic        unused_inst;

    assign opcode      = bus.inst_i[6:0];
    assign funct3      = bus.inst_i[14:12];
    assign funct7      = bus.inst_i[31:25];
    assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

    assign is_div_op = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && funct3[2];
    assign op_signed = ~funct3[0];
    assign op_rem    = funct3[1];

    assign op1_neg = op_signed & bus.op1_i[31];
    assign op2_neg = op_signed & bus.op2_i[31];
    assign op1_mag = op1_neg ? (32'd0 - bus.op1_i) : bus.op1_i;
    assign op2_mag = op2_neg ? (32'd0 - bus.op2_i) : bus.op2_i;

    // Remainder follows the dividend; quotient is negative when signs differ.
    assign res_neg = op_rem ? op1_neg : (op1_neg ^ op2_neg);

    assign div_zero = (bus.op2_i == '0);
    assign sgn_ovf  = op_signed && (bus.op1_i == 32'h8000_0000) && (bus.op2_i == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_rem ? bus.op1_i : '1;
        end else begin
            special_res = op_rem ? '0 : 32'h8000_0000;
        end
    end

`ifdef EX_DIV_EARLY_OUT_EN
    logic small_dvd;
    logic unit_dsr;

    assign small_dvd = (op1_mag < op2_mag);
    assign unit_dsr  = (op2_mag == 32'd1);
    assign early     = !div_zero && (small_dvd || unit_dsr);

    always_comb begin
        early_res = '0;
        if (small_dvd) begin
            early_res = op_rem ? bus.op1_i : '0;
        end else if (!op_rem) begin
            early_res = res_neg ? (32'd0 - op1_mag) : op1_mag;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // ------------------------------------------------------------------
    // Restoring datapath: ITER_PER_CLK steps unrolled per clock.
    // quo holds the remaining dividend bits in its top and collects the
    // quotient bits in its bottom as they are resolved.
    // ------------------------------------------------------------------
    logic [31:0] it_rem;
    logic [31:0] it_quo;
    logic [32:0] it_sh;
    logic        it_ge;
    logic [31:0] calc_res;

    always_comb begin
        it_rem = rem_q;
        it_quo = quo_q;
        it_sh  = '0;
        it_ge  = 1'b0;
        for (int unsigned i = 0; i < ITER_PER_CLK; i++) begin
            it_sh  = {it_rem, it_quo[31]};
            it_ge  = (it_sh >= {1'b0, dsr_q});
            // Partial remainder stays below the divisor, so the low 32 bits suffice.
            it_rem = it_ge ? (it_sh[31:0] - dsr_q) : it_sh[31:0];
            it_quo = {it_quo[30:0], it_ge};
        end
    end

    always_comb begin
        calc_res = '0;
        if (is_rem_q) begin
            calc_res = neg_q ? (32'd0 - it_rem) : it_rem;
        end else begin
            calc_res = neg_q ? (32'd0 - it_quo) : it_quo;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsr_d      = dsr_q;
        is_rem_d   = is_rem_q;
        neg_d      = neg_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = '0;
        wb_rd_d    = '0;

        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_div_op) begin
                        is_rem_d = op_rem;
                        neg_d    = res_neg;
                        rd_d     = bus.rd_addr_i;
                        dsr_d    = op2_mag;
                        quo_d    = op1_mag;
                        rem_d    = '0;
                        cnt_d    = '0;
                        if (div_zero || sgn_ovf) begin
                            state_d    = S_DONE;
                            wb_valid_d = 1'b1;
                            wb_data_d  = special_res;
                            wb_rd_d    = bus.rd_addr_i;
                        end else if (early) begin
                            state_d    = S_DONE;
                            wb_valid_d = 1'b1;
                            wb_data_d  = early_res;
                            wb_rd_d    = bus.rd_addr_i;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    rem_d = it_rem;
                    quo_d = it_quo;
                    if (cnt_q == CNT_LAST) begin
                        state_d    = S_DONE;
                        cnt_d      = '0;
                        wb_valid_d = 1'b1;
                        wb_data_d  = calc_res;
                        wb_rd_d    = rd_q;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the acceptance cycle itself.
    always_comb begin
        hold_c = 1'b0;
        if (!rst) begin
            hold_c = ((state_q == S_IDLE) && is_div_op && !bus.flush_i) ||
                     (state_q == S_CALC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_q      <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsr_q      <= dsr_d;
            is_rem_q   <= is_rem_d;
            neg_q      <= neg_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign bus.hold_o     = hold_c;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.wb_valid_o = wb_valid_q;
    assign bus.wb_data_o  = wb_data_q;
    assign bus.wb_rd_o    = wb_rd_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: two instances (ITER_PER_CLK = 1 and 4),
// expected results queued at issue and checked when write-back appears.
module tb_ex_div_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_div_unit_if bus1 ();
    ex_div_unit_if bus4 ();

    ex_div_unit #(.ITER_PER_CLK(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    ex_div_unit #(.ITER_PER_CLK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [2:0]  F3_DIV   = 3'b100;
    localparam logic [2:0]  F3_DIVU  = 3'b101;
    localparam logic [2:0]  F3_REM   = 3'b110;
    localparam logic [2:0]  F3_REMU  = 3'b111;
    localparam int          LAT1     = 33;
    localparam int          LAT4     = 9;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic fl);
        if (sel == 4) begin
            bus4.inst_i = inst; bus4.op1_i = a; bus4.op2_i = b;
            bus4.rd_addr_i = rd; bus4.flush_i = fl;
        end else begin
            bus1.inst_i = inst; bus1.op1_i = a; bus1.op2_i = b;
            bus1.rd_addr_i = rd; bus1.flush_i = fl;
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 4) ? bus4.wb_valid_o : bus1.wb_valid_o;
    endfunction

    function automatic logic get_hold(input int sel);
        return (sel == 4) ? bus4.hold_o : bus1.hold_o;
    endfunction

    function automatic logic [31:0] get_data(input int sel);
        return (sel == 4) ? bus4.wb_data_o : bus1.wb_data_o;
    endfunction

    function automatic logic [4:0] get_rd(input int sel);
        return (sel == 4) ? bus4.wb_rd_o : bus1.wb_rd_o;
    endfunction

    // Issue one op, wait (bounded) for the write-back pulse, check it against the queued entry.
    task automatic run_op(input int sel, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_d, input int lat, input string tag);
        exp_t e;
        int   holds;
        bit   seen;
        @(posedge clk); #1;
        drive(sel, mk_inst(7'b0000001, f3, rd), a, b, rd, 1'b0);
        e.data = exp_d; e.rd = rd; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        holds = 0;
        seen  = 1'b0;
        for (int k = 0; k <= 100 && !seen; k++) begin
            @(negedge clk);
            if (get_valid(sel)) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk({e.tag, "/data"}, get_data(sel), e.data);
                chk({e.tag, "/rd"}, 32'(get_rd(sel)), 32'(e.rd));
                chk({e.tag, "/latency"}, 32'(k), 32'(e.lat));
                chk({e.tag, "/hold_cycles"}, 32'(holds), 32'(e.lat));
                chk({e.tag, "/hold_in_done"}, 32'(get_hold(sel)), 32'd0);
            end else if (get_hold(sel)) begin
                holds++;
            end
        end
        chk({tag, "/wb_seen"}, 32'(seen), 32'd1);
        if (!seen && sb.size() > 0) void'(sb.pop_front());
        @(posedge clk); #1;
        drive(sel, NOP, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk({tag, "/valid_one_cycle"}, 32'(get_valid(sel)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int valids;
        int holds;
        int lat_small;

        rst = 1'b1;
        drive(1, NOP, '0, '0, '0, 1'b0);
        drive(4, NOP, '0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/hold",  32'(bus1.hold_o), 32'd0);
        chk("reset/busy",  32'(bus1.busy_o), 32'd0);
        chk("reset/valid", 32'(bus1.wb_valid_o), 32'd0);
        chk("reset/data",  bus1.wb_data_o, 32'd0);
        chk("reset/rd",    32'(bus1.wb_rd_o), 32'd0);
        chk("reset/busy4", 32'(bus4.busy_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic unsigned-looking signed ops, full iteration path
        run_op(1, F3_DIV,  32'd100, 32'd7, 5'd5, 32'd14, LAT1, "div_100_7");
        run_op(1, F3_REM,  32'd100, 32'd7, 5'd5, 32'd2,  LAT1, "rem_100_7");

        // Signed operands and unsigned interpretation of the same bit pattern
        run_op(1, F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, LAT1, "div_m7_2");
        run_op(1, F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, LAT1, "rem_m7_2");
        run_op(1, F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, LAT1, "divu_big_2");
        run_op(1, F3_DIV,  32'd100, 32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, LAT1, "div_100_m7");

        // Special cases resolve in one cycle
        run_op(1, F3_DIV,  32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, "div_by_zero");
        run_op(1, F3_REMU, 32'd5, 32'd0, 5'd11, 32'd5,         1, "remu_by_zero");
        run_op(1, F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, "div_ovf");
        run_op(1, F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1, "rem_ovf");

        // rd = 0 still executes and pulses
        run_op(1, F3_DIVU, 32'd20, 32'd3, 5'd0, 32'd6, LAT1, "divu_rd0");

        // Flush in CALC cycle 10 cancels without write-back
        @(posedge clk); #1;
        drive(1, mk_inst(7'b0000001, F3_DIV, 5'd14), 32'd50, 32'd5, 5'd14, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("flush/busy_before", 32'(bus1.busy_o), 32'd1);
        drive(1, NOP, '0, '0, '0, 1'b1);
        @(posedge clk); #1;
        drive(1, NOP, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk("flush/busy_after", 32'(bus1.busy_o), 32'd0);
        chk("flush/hold_after", 32'(bus1.hold_o), 32'd0);
        valids = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.wb_valid_o) valids++;
        end
        chk("flush/no_wb", 32'(valids), 32'd0);
        run_op(1, F3_DIV, 32'd9, 32'd3, 5'd15, 32'd3, LAT1, "div_9_3_after_flush");

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        drive(1, mk_inst(7'b0000001, F3_DIV, 5'd5), 32'd100, 32'd7, 5'd5, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("areset/busy_before", 32'(bus1.busy_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("areset/hold",  32'(bus1.hold_o), 32'd0);
        chk("areset/busy",  32'(bus1.busy_o), 32'd0);
        chk("areset/valid", 32'(bus1.wb_valid_o), 32'd0);
        chk("areset/data",  bus1.wb_data_o, 32'd0);
        chk("areset/rd",    32'(bus1.wb_rd_o), 32'd0);
        drive(1, mk_inst(7'b0000000, 3'b000, 5'd3), 32'd4, 32'd5, 5'd3, 1'b0);
        #1;
        rst = 1'b0;
        holds  = 0;
        valids = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus1.hold_o) holds++;
            if (bus1.wb_valid_o) valids++;
        end
        chk("add/hold", 32'(holds), 32'd0);
        chk("add/no_wb", 32'(valids), 32'd0);
        chk("add/busy", 32'(bus1.busy_o), 32'd0);
        @(posedge clk); #1;
        drive(1, NOP, '0, '0, '0, 1'b0);

        // Four bits per clock
        run_op(4, F3_DIVU, 32'd1000, 32'd10, 5'd9, 32'd100, LAT4, "iter4_divu_1000_10");
        run_op(4, F3_REM,  32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE, LAT4, "iter4_rem_m100_7");
`ifdef EX_DIV_EARLY_OUT_EN
        lat_small = 1;
`else
        lat_small = LAT4;
`endif
        run_op(4, F3_DIV, 32'd3, 32'd8, 5'd2, 32'd0, lat_small, "iter4_div_3_8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide/remainder unit on the EX side of the ID/EX pipeline register.
- Consumes the registered instruction, operands and destination register.
- Holds the pipeline through control while it runs a restoring division.
- Presents a one-cycle write-back result. A pipeline flush (jump) cancels it.

Parameters:
- ITER_PER_CLK, 1: quotient bits resolved per clock; legal values 1, 2, 4. Iteration cycles N = 32/ITER_PER_CLK.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_i  in  32  instruction from the ID/EX register
- op1_i  in  32  rs1 value (dividend)
- op2_i  in  32  rs2 value (divisor)
- rd_addr_i  in  5  destination register
- flush_i  in  1  jump/flush from control; cancels any operation
- hold_o  out  1  stall request to control; freezes IF/ID/ID-EX
- busy_o  out  1  state != IDLE
- wb_valid_o  out  1  result valid this cycle (one-cycle pulse)
- wb_data_o  out  32  quotient or remainder
- wb_rd_o  out  5  destination register of the result

Behaviour:
- Decode: the unit recognises a div op when opcode = 7'b0110011, funct7 = 7'b0000001 and funct3 is one of:
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- States:
  - IDLE
    - Div op present and flush_i = 0: latch op type, rd, |op1|, |op2| (signed ops) or raw values (unsigned ops), and the result sign.
    - Divisor == 0 or signed overflow: go to DONE.
    - Otherwise: clear the partial remainder and go to CALC.
  - CALC
    - Each clock performs ITER_PER_CLK restoring steps: shift remainder:dividend left 1, trial-subtract the divisor, set the quotient bit if non-negative.
    - An iteration counter counts N cycles, then the FSM goes to DONE.
  - DONE
    - Drives wb_valid_o = 1 with the sign-corrected result, then returns to IDLE unconditionally.
    - Does not re-accept inst_i this cycle; the pipeline advances at this edge.
- Latency: accept edge → N CALC cycles → DONE. wb_valid_o is high in cycle N+1 after acceptance (33 for ITER_PER_CLK = 1). Special cases give wb_valid_o in cycle 1.
- hold_o (combinational):
  - = 1 in IDLE when a div op is decoded and flush_i = 0.
  - = 1 throughout CALC.
  - = 0 in DONE.
- Special results:
  - Divide by zero: DIV/DIVU → 32'hFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (0x80000000 / -1): DIV → 0x80000000; REM → 0.
- Sign rules:
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- flush_i in any state: next state IDLE, wb_valid_o forced 0 that cycle, and no result is produced for the cancelled op.
- rd_addr_i = 0: the operation still executes and wb_valid_o still pulses; wb_rd_o = 0 and the regfile discards the write.
- Reset (async): state IDLE, counter 0, hold_o = 0, busy_o = 0, wb_valid_o = 0, wb_data_o = 0, wb_rd_o = 0. Reset mid-CALC aborts with no write-back.
- Non-div instructions in IDLE: ignored. All outputs except hold_o are registered.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN
- Defined:
  - In IDLE, if the effective dividend magnitude < divisor magnitude (nonzero divisor), go directly to DONE.
  - Result: quotient 0, remainder = dividend; wb_valid_o in cycle 1.
  - The same early-out applies when the divisor is 1: quotient = dividend, remainder = 0.
- Undefined: all non-special cases take the full N-cycle path.

Test Plan:
- DIV 100 / 7, rd = 5, ITER_PER_CLK = 1:
  - hold_o high 33 cycles.
  - wb_valid_o pulses cycle 33 with wb_data_o = 14 and wb_rd_o = 5.
  - Then REM on the same operands → 2.
- Signed operands:
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Special cases:
  - DIV 5 / 0 → 0xFFFFFFFF in cycle 1.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- flush_i asserted in CALC cycle 10 → IDLE next edge, no wb_valid_o pulse. A following DIV 9 / 3 → 3 with correct latency.
- rst asserted asynchronously mid-CALC:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, an ADD instruction → hold_o stays 0.
- ITER_PER_CLK = 4: DIVU 1000 / 10 → 100 in cycle 9. With EX_DIV_EARLY_OUT_EN, DIV 3 / 8 → 0 in cycle 1.
